// File: rtl/ppi8255.sv
// 8255-compatible programmable peripheral interface: control register, BSR words,
// input synchronisers and optional mode 1 strobed input on port A (macro PPI_MODE1_EN).
module ppi8255 #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] CTRL_RESET  = 8'h9B
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cs,
    input  logic       rnw,
    input  logic [1:0] addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic [7:0] pa_i,
    input  logic [7:0] pb_i,
    input  logic [7:0] pc_i,
    output logic [7:0] pa_o,
    output logic [7:0] pb_o,
    output logic [7:0] pc_o,
    output logic [7:0] pa_oe,
    output logic [7:0] pb_oe,
    output logic [7:0] pc_oe
);

    logic [7:0] ctrl_r;
    logic [7:0] pa_lat_r;
    logic [7:0] pb_lat_r;
    logic [7:0] pc_lat_r;
    logic [7:0] pa_sync_s;
    logic [7:0] pb_sync_s;
    logic [7:0] pc_sync_s;
    logic [7:0] pa_base_s;
    logic [7:0] pc_base_s;
    logic [7:0] pc_oe_base_s;
    logic [7:0] pa_rd_s;
    logic [7:0] pc_rd_s;
    logic       wr_s;

    assign wr_s = cs & ~rnw;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign pa_sync_s = pa_i;
            assign pb_sync_s = pb_i;
            assign pc_sync_s = pc_i;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0][7:0] pa_q_r;
            logic [SYNC_STAGES-1:0][7:0] pb_q_r;
            logic [SYNC_STAGES-1:0][7:0] pc_q_r;

            // Pin synchroniser shift chains
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    pa_q_r <= '0;
                    pb_q_r <= '0;
                    pc_q_r <= '0;
                end else begin
                    pa_q_r[0] <= pa_i;
                    pb_q_r[0] <= pb_i;
                    pc_q_r[0] <= pc_i;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        pa_q_r[i] <= pa_q_r[i-1];
                        pb_q_r[i] <= pb_q_r[i-1];
                        pc_q_r[i] <= pc_q_r[i-1];
                    end
                end
            end

            assign pa_sync_s = pa_q_r[SYNC_STAGES-1];
            assign pb_sync_s = pb_q_r[SYNC_STAGES-1];
            assign pc_sync_s = pc_q_r[SYNC_STAGES-1];
        end
    endgenerate

    // Control register and output latches; a mode-set word clears all latches
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_r   <= CTRL_RESET;
            pa_lat_r <= 8'h00;
            pb_lat_r <= 8'h00;
            pc_lat_r <= 8'h00;
        end else if (wr_s) begin
            case (addr)
                2'd0: pa_lat_r <= din;
                2'd1: pb_lat_r <= din;
                2'd2: pc_lat_r <= din;
                2'd3: begin
                    if (din[7]) begin
                        ctrl_r   <= din;
                        pa_lat_r <= 8'h00;
                        pb_lat_r <= 8'h00;
                        pc_lat_r <= 8'h00;
                    end else begin
                        pc_lat_r[din[3:1]] <= din[0];
                    end
                end
                default: ctrl_r <= ctrl_r;
            endcase
        end
    end

    assign pa_base_s    = ctrl_r[4] ? pa_sync_s : pa_lat_r;
    assign pc_base_s    = {ctrl_r[3] ? pc_sync_s[7:4] : pc_lat_r[7:4],
                           ctrl_r[0] ? pc_sync_s[3:0] : pc_lat_r[3:0]};
    assign pc_oe_base_s = {{4{~ctrl_r[3]}}, {4{~ctrl_r[0]}}};

    assign pa_o  = pa_lat_r;
    assign pb_o  = pb_lat_r;
    assign pa_oe = {8{~ctrl_r[4]}};
    assign pb_oe = {8{~ctrl_r[1]}};

`ifdef PPI_MODE1_EN
    logic       inte_r;
    logic       ibf_r;
    logic       intr_r;
    logic       stb_prev_r;
    logic [7:0] pa_in_r;
    logic       mode1_s;
    logic       rd_pa_s;
    logic       mode_set_s;
    logic       bsr_s;
    logic       stb_fall_s;
    logic       stb_rise_s;

    assign mode1_s    = (ctrl_r[6:5] == 2'b01);
    assign rd_pa_s    = cs & rnw & (addr == 2'd0);
    assign mode_set_s = wr_s & (addr == 2'd3) & din[7];
    assign bsr_s      = wr_s & (addr == 2'd3) & ~din[7];
    assign stb_fall_s = stb_prev_r & ~pc_sync_s[4];
    assign stb_rise_s = ~stb_prev_r & pc_sync_s[4];

    // Mode 1 port A handshake; a same-cycle fall re-arms IBF after a read clears it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inte_r     <= 1'b0;
            ibf_r      <= 1'b0;
            intr_r     <= 1'b0;
            stb_prev_r <= 1'b1;
            pa_in_r    <= 8'h00;
        end else begin
            stb_prev_r <= pc_sync_s[4];
            if (mode_set_s) begin
                inte_r <= 1'b0;
                ibf_r  <= 1'b0;
                intr_r <= 1'b0;
            end else if (mode1_s) begin
                if (bsr_s && (din[3:1] == 3'd4)) begin
                    inte_r <= din[0];
                end
                if (stb_fall_s) begin
                    pa_in_r <= pa_sync_s;
                    ibf_r   <= 1'b1;
                end else if (rd_pa_s) begin
                    ibf_r <= 1'b0;
                end
                if (rd_pa_s) begin
                    intr_r <= 1'b0;
                end else if (stb_rise_s) begin
                    intr_r <= inte_r & ibf_r;
                end
            end
        end
    end

    // Port C pins and read data with handshake bits overlaid in mode 1
    always_comb begin
        pc_o    = pc_lat_r;
        pc_oe   = pc_oe_base_s;
        pc_rd_s = pc_base_s;
        pa_rd_s = pa_base_s;
        if (mode1_s) begin
            pc_o[5]    = ibf_r;
            pc_o[3]    = intr_r;
            pc_oe[5]   = 1'b1;
            pc_oe[4]   = 1'b0;
            pc_oe[3]   = 1'b1;
            pc_rd_s[5] = ibf_r;
            pc_rd_s[4] = inte_r;
            pc_rd_s[3] = intr_r;
            if (ctrl_r[4]) begin
                pa_rd_s = pa_in_r;
            end else begin
                pa_rd_s = pa_lat_r;
            end
        end else begin
            pc_o    = pc_lat_r;
            pc_oe   = pc_oe_base_s;
            pc_rd_s = pc_base_s;
            pa_rd_s = pa_base_s;
        end
    end
`else
    assign pc_o    = pc_lat_r;
    assign pc_oe   = pc_oe_base_s;
    assign pc_rd_s = pc_base_s;
    assign pa_rd_s = pa_base_s;
`endif

    // Read mux, not gated by cs
    always_comb begin
        case (addr)
            2'd0:    dout = pa_rd_s;
            2'd1:    dout = pb_base_mux(ctrl_r[1], pb_sync_s, pb_lat_r);
            2'd2:    dout = pc_rd_s;
            2'd3:    dout = ctrl_r;
            default: dout = 8'h00;
        endcase
    end

    function automatic logic [7:0] pb_base_mux(input logic in_dir,
                                               input logic [7:0] pin,
                                               input logic [7:0] lat);
        if (in_dir) begin
            return pin;
        end else begin
            return lat;
        end
    endfunction

endmodule

// File: tb/tb_ppi8255.sv
// Randomised self-checking bench for ppi8255 against a behavioural port model.
module tb_ppi8255;

    localparam int         SYNC = 2;
    localparam logic [7:0] CRST = 8'h8A;
`ifdef PPI_MODE1_EN
    localparam bit M1 = 1'b1;
`else
    localparam bit M1 = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cs = 1'b0;
    logic       rnw = 1'b1;
    logic [1:0] addr = 2'd0;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;
    logic [7:0] pa_i = 8'h00, pb_i = 8'h00, pc_i = 8'hFF;
    logic [7:0] pa_o, pb_o, pc_o, pa_oe, pb_oe, pc_oe;

    int n_checks = 0;
    int n_fail = 0;

    logic [7:0] m_ctrl, m_pa, m_pb, m_pc, m_pa_in;
    logic       m_inte, m_ibf, m_intr, m_stb_prev;
    logic [7:0] pa_h[$], pb_h[$], pc_h[$];

    ppi8255 #(.SYNC_STAGES(SYNC), .CTRL_RESET(CRST)) dut (
        .clk(clk), .reset_n(reset_n), .cs(cs), .rnw(rnw), .addr(addr), .din(din),
        .dout(dout), .pa_i(pa_i), .pb_i(pb_i), .pc_i(pc_i),
        .pa_o(pa_o), .pb_o(pb_o), .pc_o(pc_o),
        .pa_oe(pa_oe), .pb_oe(pb_oe), .pc_oe(pc_oe)
    );

    always #5 clk = ~clk;

    task automatic check8(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        m_ctrl = CRST; m_pa = 8'h00; m_pb = 8'h00; m_pc = 8'h00; m_pa_in = 8'h00;
        m_inte = 1'b0; m_ibf = 1'b0; m_intr = 1'b0; m_stb_prev = 1'b1;
        pa_h.delete(); pb_h.delete(); pc_h.delete();
        for (int i = 0; i < SYNC; i++) begin
            pa_h.push_back(8'h00); pb_h.push_back(8'h00); pc_h.push_back(8'h00);
        end
    endtask

    function automatic bit m_mode1();
        return M1 && (m_ctrl[6:5] == 2'b01);
    endfunction

    function automatic logic [7:0] m_dout(input logic [1:0] a);
        logic [7:0] v;
        case (a)
            2'd0: v = m_ctrl[4] ? (m_mode1() ? m_pa_in : pa_h[0]) : m_pa;
            2'd1: v = m_ctrl[1] ? pb_h[0] : m_pb;
            2'd2: begin
                v[7:4] = m_ctrl[3] ? pc_h[0][7:4] : m_pc[7:4];
                v[3:0] = m_ctrl[0] ? pc_h[0][3:0] : m_pc[3:0];
                if (m_mode1()) begin
                    v[5] = m_ibf; v[4] = m_inte; v[3] = m_intr;
                end
            end
            default: v = m_ctrl;
        endcase
        return v;
    endfunction

    function automatic logic [7:0] m_pc_oe();
        logic [7:0] v;
        v = {{4{~m_ctrl[3]}}, {4{~m_ctrl[0]}}};
        if (m_mode1()) begin
            v[5] = 1'b1; v[4] = 1'b0; v[3] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [7:0] m_pc_o();
        logic [7:0] v;
        v = m_pc;
        if (m_mode1()) begin
            v[5] = m_ibf; v[3] = m_intr;
        end
        return v;
    endfunction

    // Advance the model by one clock edge using the inputs currently driven
    task automatic m_step();
        logic [7:0] sa, sc;
        logic m1, rd, ws, ms, fall, rise, o_inte, o_ibf;
        sa = pa_h[0]; sc = pc_h[0];
        m1 = m_mode1();
        rd = cs && rnw && (addr == 2'd0);
        ws = cs && !rnw;
        ms = ws && (addr == 2'd3) && din[7];
        fall = m_stb_prev && !sc[4];
        rise = !m_stb_prev && sc[4];
        o_inte = m_inte; o_ibf = m_ibf;
        if (ws) begin
            if (addr == 2'd0) m_pa = din;
            else if (addr == 2'd1) m_pb = din;
            else if (addr == 2'd2) m_pc = din;
            else if (din[7]) begin
                m_ctrl = din; m_pa = 8'h00; m_pb = 8'h00; m_pc = 8'h00;
                m_inte = 1'b0; m_ibf = 1'b0; m_intr = 1'b0;
            end else begin
                m_pc[din[3:1]] = din[0];
                if (m1 && din[3:1] == 3'd4) m_inte = din[0];
            end
        end
        if (m1 && !ms) begin
            if (rd) begin m_ibf = 1'b0; m_intr = 1'b0; end
            if (fall) begin m_pa_in = sa; m_ibf = 1'b1; end
            if (rise && !rd) m_intr = o_inte & o_ibf;
        end
        m_stb_prev = sc[4];
        pa_h.push_back(pa_i); void'(pa_h.pop_front());
        pb_h.push_back(pb_i); void'(pb_h.pop_front());
        pc_h.push_back(pc_i); void'(pc_h.pop_front());
    endtask

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            m_step();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        cs = 1'b1; rnw = 1'b0; addr = a; din = d;
        tick();
        cs = 1'b0; rnw = 1'b1;
    endtask

    task automatic bus_read_pa();
        cs = 1'b1; rnw = 1'b1; addr = 2'd0;
        tick();
        cs = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [7:0] v);
        addr = a;
        #1;
        v = dout;
    endtask

    task automatic check_outs(input string tag);
        logic [7:0] v;
        check8({tag, "_pa_o"}, pa_o, m_pa);
        check8({tag, "_pb_o"}, pb_o, m_pb);
        check8({tag, "_pc_o"}, pc_o, m_pc_o());
        check8({tag, "_pa_oe"}, pa_oe, {8{~m_ctrl[4]}});
        check8({tag, "_pb_oe"}, pb_oe, {8{~m_ctrl[1]}});
        check8({tag, "_pc_oe"}, pc_oe, m_pc_oe());
        for (int a = 0; a < 4; a++) begin
            rd(a[1:0], v);
            check8($sformatf("%s_dout%0d", tag, a), v, m_dout(a[1:0]));
        end
    endtask

    initial begin
        logic [7:0] v;
        logic [1:0] a;
        int op;
        m_reset();
        #12 reset_n = 1'b1;

        // Reset state with the Atom control word
        check8("rst_pa_oe", pa_oe, 8'hFF);
        check8("rst_pb_oe", pb_oe, 8'h00);
        check8("rst_pc_oe", pc_oe, 8'h0F);
        check8("rst_pa_o", pa_o, 8'h00);
        check8("rst_pb_o", pb_o, 8'h00);
        check8("rst_pc_o", pc_o, 8'h00);
        rd(2'd3, v); check8("rst_ctrl", v, 8'h8A);

        // All-input mode and pin latency
        bus_write(2'd3, 8'h9B);
        check8("in_pa_oe", pa_oe, 8'h00);
        check8("in_pb_oe", pb_oe, 8'h00);
        check8("in_pc_oe", pc_oe, 8'h00);
        pb_i = 8'h5A;
        tick();
        rd(2'd1, v); check8("pb_lat1", v, 8'h00);
        tick();
        rd(2'd1, v); check8("pb_lat2", v, 8'h5A);
        check_outs("d9b");

        // BSR on port C
        bus_write(2'd3, 8'h8A);
        bus_write(2'd2, 8'h05); check8("bsr_pc0", pc_o, 8'h05);
        bus_write(2'd3, 8'h07); check8("bsr_pc1", pc_o, 8'h0D);
        bus_write(2'd3, 8'h00); check8("bsr_pc2", pc_o, 8'h0C);
        rd(2'd3, v); check8("bsr_ctrl", v, 8'h8A);

        // Mode set clears latches
        bus_write(2'd0, 8'h3C); check8("ms_pa_pre", pa_o, 8'h3C);
        bus_write(2'd3, 8'h80);
        check8("ms_pa_o", pa_o, 8'h00);
        check8("ms_pc_o", pc_o, 8'h00);
        rd(2'd3, v); check8("ms_ctrl", v, 8'h80);
        check_outs("d80");

`ifdef PPI_MODE1_EN
        // Mode 1 strobed input
        bus_write(2'd3, 8'hB8);
        bus_write(2'd3, 8'h09);
        check8("m1_pc_oe", pc_oe, 8'h2F);
        pa_i = 8'hA5; pc_i = 8'hEF;
        tick(3);
        rd(2'd2, v); check8("m1_ibf", v & 8'h38, 8'h30);
        pc_i = 8'hFF;
        tick(3);
        rd(2'd2, v); check8("m1_intr", v & 8'h38, 8'h38);
        pa_i = 8'h00;
        tick(2);
        rd(2'd0, v); check8("m1_pa_latch", v, 8'hA5);
        bus_read_pa();
        rd(2'd2, v); check8("m1_rdclr", v & 8'h38, 8'h10);
        check_outs("m1a");

        // Strobe fall coincident with a PA read
        pc_i = 8'hEF; tick(3);
        pc_i = 8'hFF; tick(3);
        rd(2'd2, v); check8("co_pre", v & 8'h38, 8'h38);
        pa_i = 8'h3C; pc_i = 8'hEF;
        tick(2);
        bus_read_pa();
        rd(2'd2, v); check8("co_flags", v & 8'h38, 8'h30);
        rd(2'd0, v); check8("co_latch", v, 8'h3C);
        pc_i = 8'hFF; tick(3);

        // Reset during a pending IBF
        #1 reset_n = 1'b0;
        #1;
        check8("ar_ibf", {7'd0, dut.ibf_r}, 8'h00);
        check8("ar_intr", {7'd0, dut.intr_r}, 8'h00);
        check8("ar_inte", {7'd0, dut.inte_r}, 8'h00);
        m_reset();
        #1 reset_n = 1'b1;
        check_outs("ar");
`else
        // Without the handshake a mode 1 word leaves port C as plain mode 0
        bus_write(2'd3, 8'hB8);
        check8("nm1_pc_oe", pc_oe, 8'h0F);
        pc_i = 8'hA7;
        tick(2);
        rd(2'd2, v); check8("nm1_pc_rd", v, 8'hA0);
        check_outs("nm1");
`endif

        // Randomised bus traffic and pin activity
        for (int it = 0; it < 400; it++) begin
            pa_i = 8'($urandom); pb_i = 8'($urandom); pc_i = 8'($urandom);
            op = $urandom_range(0, 9);
            if (op < 4) begin
                a = 2'($urandom_range(0, 3));
                v = 8'($urandom);
                if (a == 2'd3 && v[7] && $urandom_range(0, 1) == 1) v[6:5] = 2'b01;
                bus_write(a, v);
            end else if (op < 7) begin
                bus_read_pa();
            end else begin
                tick();
            end
            check_outs("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
